flex_stp_rx: RTL and testbench
==============================

FLEX_STP_RX -- requirements
Module: flex_stp_rx

Interface
REQ-001 Parameter NUM_BITS, default 32, data bits per frame (SHALL be >= 2).
REQ-002 Parameter SHIFT_MSB, default 1; 1 = first received data bit is rx_data MSB, 0 = first received bit is LSB.
REQ-003 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit (SHALL be >= 2).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 n_rst  input  1  asynchronous, active-low reset.
REQ-006 serial_in  input  1  serial line, idle high.
REQ-007 rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 rx_data  output  NUM_BITS  received word.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overflow  output  1  one-cycle pulse: completed word dropped because the buffer was full.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 serial_in SHALL pass through a 2-flop synchronizer (reset value 1); "s" below is its output, and "s_prev" is s delayed one cycle.
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP, plus a bit counter (0..CLKS_PER_BIT-1) and a bit index (0..NUM_BITS-1).
REQ-015 In IDLE, s==0 with s_prev==1 SHALL move the FSM to START and clear the bit counter; a line held low SHALL NOT trigger a frame.
REQ-016 START SHALL sample s when the bit counter equals CLKS_PER_BIT/2 (integer division).
- s==0: go to DATA, clear the bit counter and the bit index.
- s==1: treat as a glitch and return to IDLE with no error.
REQ-017 DATA SHALL sample s each time the bit counter wraps from CLKS_PER_BIT-1 to 0.
- Shift the sample into an internal shift register: enter at LSB and shift left if SHIFT_MSB=1, enter at MSB and shift right if SHIFT_MSB=0.
- After the NUM_BITS-th sample, go to STOP.
REQ-018 STOP SHALL sample s after CLKS_PER_BIT cycles, then return to IDLE.
- s==1: the word is complete.
- s==0: discard the word and pulse framing_error for one cycle.
REQ-019 On completion with rx_valid==0, or with rx_valid==1 and rx_ready==1 in the same cycle, the next cycle SHALL show rx_data = the new word and rx_valid = 1.
REQ-020 On completion with rx_valid==1 and rx_ready==0, rx_data and rx_valid SHALL remain unchanged, and overflow SHALL pulse for one cycle.
REQ-021 rx_valid==1 with rx_ready==1 and no completion SHALL clear rx_valid next cycle; rx_data SHALL hold its last value.
REQ-022 rx_ready while rx_valid==0 SHALL have no effect.
REQ-023 After a framing error, a new frame SHALL begin only after s has returned high and then fallen again.
REQ-024 Reception SHALL continue independently of the output buffer state; back-to-back frames with a single stop bit SHALL be received without loss.

Reset
REQ-025 n_rst low SHALL immediately force the FSM to IDLE, clear the counters, and set the synchronizer and shift register to all 1s.
REQ-026 n_rst low SHALL immediately set rx_data to all 1s, and set rx_valid=0, framing_error=0, overflow=0 and busy=0.
REQ-027 A reset asserted mid-frame SHALL abandon the frame; the first falling edge after release SHALL start a new frame.

Verification
(All scenarios use NUM_BITS=8, CLKS_PER_BIT=4.)
REQ-028 SHIFT_MSB=1; send start bit, then 0xA5 MSB first, then stop bit, with rx_ready=0 -> rx_valid=1, rx_data=0xA5, no error pulses.
REQ-029 SHIFT_MSB=0; send 0x3C LSB first -> rx_data=0x3C.
REQ-030 Send 0x11 then 0x22 back-to-back, with rx_ready=0 throughout -> rx_data stays 0x11 and overflow pulses once.
- Then pulse rx_ready for one cycle -> rx_valid=0.
REQ-031 Send 0x55 with the stop bit low -> framing_error pulses once, rx_valid stays 0.
- Then hold the line high and send 0x66 -> rx_data=0x66.
REQ-032 Drive a 1-cycle low glitch on an idle line -> no rx_valid, no framing_error, busy returns to 0 within 6 cycles.
REQ-033 Assert n_rst during the 4th data bit -> all outputs return to reset values.
- Then send 0x81 -> rx_data=0x81.

Source files
------------

// File: rtl/flex_stp_rx.sv
// Serial-to-parallel UART-style receiver: start bit, NUM_BITS data bits, one stop bit,
// oversampled at CLKS_PER_BIT, with a single-word output buffer and error pulses.
module flex_stp_rx #(
    parameter int NUM_BITS     = 32,
    parameter int SHIFT_MSB    = 1,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_in,
    input  logic                rx_ready,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                framing_error,
    output logic                overflow,
    output logic                busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [IW-1:0]       idx, idx_next;
    logic                sync_p0, sync_p1, s_prev;
    logic                s;
    logic [NUM_BITS-1:0] shreg;
    logic                shift_en, done, ferr;

    assign s    = sync_p1;
    assign busy = (state != IDLE);

    // Stage p0/p1: metastability synchronizer, idle-high reset so no false start edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            s_prev  <= 1'b1;
        end else begin
            sync_p0 <= serial_in;
            sync_p1 <= sync_p0;
            s_prev  <= sync_p1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_en   = 1'b0;
        done       = 1'b0;
        ferr       = 1'b0;
        case (state)
            IDLE: begin
                // Edge-triggered so a line stuck low never starts a frame
                if (!s && s_prev) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    if (!s) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_MAX) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    if (idx == IDX_MAX) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done       = s;
                    ferr       = !s;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shreg <= '1;
        end else if (shift_en) begin
            if (SHIFT_MSB != 0) begin
                shreg <= {shreg[NUM_BITS-2:0], s};
            end else begin
                shreg <= {s, shreg[NUM_BITS-1:1]};
            end
        end
    end

    // Output buffer: a full, unconsumed buffer drops the new word and flags overflow
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '1;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            framing_error <= ferr;
            overflow      <= done && rx_valid && !rx_ready;
            if (done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_flex_stp_rx.sv
// Directed bench for flex_stp_rx (NUM_BITS=8, CLKS_PER_BIT=4): vector table for
// single frames plus hand-written overflow, framing, glitch and reset sequences.
module tb_flex_stp_rx;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, ferr_m, ferr_l, ovf_m, ovf_l, busy_m, busy_l;

    int n_vec = 0;
    int n_fail = 0;
    int ferr_cnt_m = 0, ferr_cnt_l = 0, ovf_cnt_m = 0, ovf_cnt_l = 0, busy_seen = 0;

    always #5 clk = ~clk;

    flex_stp_rx #(.NUM_BITS(8), .SHIFT_MSB(1), .CLKS_PER_BIT(4)) dut_msb (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .rx_ready(rx_ready),
        .rx_data(data_m), .rx_valid(valid_m), .framing_error(ferr_m),
        .overflow(ovf_m), .busy(busy_m));

    flex_stp_rx #(.NUM_BITS(8), .SHIFT_MSB(0), .CLKS_PER_BIT(4)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .rx_ready(rx_ready),
        .rx_data(data_l), .rx_valid(valid_l), .framing_error(ferr_l),
        .overflow(ovf_l), .busy(busy_l));

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (ferr_m) ferr_cnt_m <= ferr_cnt_m + 1;
        if (ferr_l) ferr_cnt_l <= ferr_cnt_l + 1;
        if (ovf_m)  ovf_cnt_m  <= ovf_cnt_m + 1;
        if (ovf_l)  ovf_cnt_l  <= ovf_cnt_l + 1;
        if (busy_m) busy_seen  <= busy_seen + 1;
    end

    typedef struct {
        logic [7:0] data;
        bit         msb;
        bit         stop;
        bit         ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit msb_first, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(msb_first ? d[7-i] : d[i]);
        send_bit(stop);
        serial_in = 1'b1;
    endtask

    task automatic do_reset();
        serial_in = 1'b1;
        n_rst = 1'b0;
        tick(2);
        n_rst = 1'b1;
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_m"},  32'(data_m),  32'hFF);
        check({tag, "_valid_m"}, 32'(valid_m), 32'h0);
        check({tag, "_ferr_m"},  32'(ferr_m),  32'h0);
        check({tag, "_ovf_m"},   32'(ovf_m),   32'h0);
        check({tag, "_busy_m"},  32'(busy_m),  32'h0);
        check({tag, "_data_l"},  32'(data_l),  32'hFF);
        check({tag, "_valid_l"}, 32'(valid_l), 32'h0);
    endtask

    initial begin
        int f0, o0, b0;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 0};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 0};
        vecs[5] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 0};

        tick(2);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        tick(2);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            f0 = vecs[v].msb ? ferr_cnt_m : ferr_cnt_l;
            o0 = vecs[v].msb ? ovf_cnt_m : ovf_cnt_l;
            rx_ready = vecs[v].ready;
            send_frame(vecs[v].data, vecs[v].msb, vecs[v].stop);
            tick(6);
            rx_ready = 1'b0;
            check($sformatf("vec%0d_valid", v), 32'(vecs[v].msb ? valid_m : valid_l), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v),  32'(vecs[v].msb ? data_m : data_l),   32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v),  32'((vecs[v].msb ? ferr_cnt_m : ferr_cnt_l) - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_ovf", v),   32'((vecs[v].msb ? ovf_cnt_m : ovf_cnt_l) - o0), 32'h0);
        end

        // Back-to-back frames with no consumer: second word overflows
        do_reset();
        o0 = ovf_cnt_m;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        tick(6);
        check("b2b_data",  32'(data_m),  32'h11);
        check("b2b_valid", 32'(valid_m), 32'h1);
        check("b2b_ovf",   32'(ovf_cnt_m - o0), 32'h1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("consume_valid", 32'(valid_m), 32'h0);
        check("consume_data",  32'(data_m),  32'h11);

        // Framing error, then recovery on a fresh edge
        do_reset();
        f0 = ferr_cnt_m;
        send_frame(8'h55, 1'b1, 1'b0);
        tick(6);
        check("ferr_pulse", 32'(ferr_cnt_m - f0), 32'h1);
        check("ferr_valid", 32'(valid_m), 32'h0);
        tick(4);
        send_frame(8'h66, 1'b1, 1'b1);
        tick(6);
        check("after_ferr_data",  32'(data_m),  32'h66);
        check("after_ferr_valid", 32'(valid_m), 32'h1);

        // One-cycle glitch on an idle line
        do_reset();
        f0 = ferr_cnt_m;
        b0 = busy_seen;
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(6);
        check("glitch_busy",      32'(busy_m), 32'h0);
        check("glitch_busy_seen", 32'(busy_seen > b0), 32'h1);
        check("glitch_valid",     32'(valid_m), 32'h0);
        check("glitch_ferr",      32'(ferr_cnt_m - f0), 32'h0);

        // Reset asserted during the 4th data bit of 0xF0 (MSB first: 1,1,1,1,...)
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        serial_in = 1'b1;
        tick(2);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick(3);
        n_rst = 1'b1;
        tick(4);
        send_frame(8'h81, 1'b1, 1'b1);
        tick(6);
        check("midrst_data",  32'(data_m),  32'h81);
        check("midrst_valid", 32'(valid_m), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
